// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//   Receive side of the board UART. Recovers bytes from the asynchronous rx
//   pin using 16x oversampling, a 2-FF synchroniser and mid-bit sampling.
//   It checks start-bit validity and framing. Each good byte is presented on
//   rx_data with a one-cycle rx_valid pulse and is mirrored on the LEDs.
//
//   Build option: define UART_RX_PARITY_EN to receive 8E1 frames with an
//   even-parity check. Leave it undefined for plain 8N1, where parity_err is
//   tied low.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   rx          asynchronous serial input, idle high
//   rx_data     last good byte, held until the next rx_valid
//   rx_valid    1-cycle pulse: rx_data updated this cycle
//   frame_err   1-cycle pulse: stop bit sampled low
//   parity_err  1-cycle pulse: parity mismatch (0 without UART_RX_PARITY_EN)
//   busy        high from start-bit detect until return to IDLE
//   led         mirrors rx_data
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OS_DIV     = CLOCK_FREQ / (BAUD_RATE * 16)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy,
    output logic [7:0] led
);

    localparam int TW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OS_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          sync_ff;
    logic          rx_s;
    logic          rx_prev;

    state_t        state, state_next;
    logic [3:0]    os_cnt, os_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          valid_next;
    logic          ferr_next;

    assign tick = (tick_cnt == TICK_LAST);
    assign busy = (state != IDLE);
    assign led  = rx_data;

    // Free-running oversample tick generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Synchroniser resets to idle-high. rx_prev resets low, so a line held
    // low through reset must be seen high before a start edge can count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b0;
        end else begin
            sync_ff <= rx;
            rx_s    <= sync_ff;
            if (tick) begin
                rx_prev <= rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad, parity_bad_next;
    logic perr_next;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            os_cnt    <= os_cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            rx_valid  <= valid_next;
            frame_err <= ferr_next;
            if (valid_next) begin
                rx_data <= shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_bad <= parity_bad_next;
            parity_err <= perr_next;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Next-state logic; everything advances only on an oversample tick.
    always_comb begin
        state_next   = state;
        os_cnt_next  = os_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad;
        perr_next       = 1'b0;
`endif
        if (tick) begin
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state_next  = START;
                        os_cnt_next = '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit after the edge to reject glitches.
                    if (os_cnt == 4'd7) begin
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            state_next   = DATA;
                            os_cnt_next  = '0;
                            bit_idx_next = '0;
                        end
                    end else begin
                        os_cnt_next = os_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (os_cnt == 4'd15) begin
                        shift_next  = {rx_s, shift[7:1]};
                        os_cnt_next = '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_idx_next = bit_idx + 3'd1;
                        end
                    end else begin
                        os_cnt_next = os_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (os_cnt == 4'd15) begin
                        parity_bad_next = (rx_s != ^shift);
                        os_cnt_next     = '0;
                        state_next      = STOP;
                    end else begin
                        os_cnt_next = os_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leaving mid stop bit lets a back-to-back start edge be caught.
                    if (os_cnt == 4'd15) begin
                        os_cnt_next = '0;
                        if (rx_s) begin
                            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad) begin
                                perr_next = 1'b1;
                            end else begin
                                valid_next = 1'b1;
                            end
`else
                            valid_next = 1'b1;
`endif
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = WAIT_HIGH;
                        end
                    end else begin
                        os_cnt_next = os_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A break or garbage is not re-framed until the line recovers.
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
//   Self-checking bench for uart_rx_sampler at 160 clk per bit (OS_DIV=10).
//   A frame-level reference model predicts, for each transmitted frame,
//   which pulse should appear and the value rx_data/led should then hold.
//   A monitor records every output pulse, and the expected and observed
//   event lists are compared after each directed step. Frames are sent with
//   a parity bit when UART_RX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int CLOCK_FREQ = 1_600_000;
    localparam int BAUD_RATE  = 10_000;
    localparam int BIT_CLKS   = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;
    logic [7:0] led;

    uart_rx_sampler #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy),
        .led       (led)
    );

    always #5 clk = ~clk;

    // pulses = {parity_err, frame_err, rx_valid}
    typedef struct {
        logic [2:0] pulses;
        logic [7:0] data;
        logic [7:0] led;
    } frame_evt_t;

    frame_evt_t obs_q[$];
    frame_evt_t exp_q[$];
    int         obs_rd = 0;
    int         exp_rd = 0;
    int         busy_cycles = 0;
    logic [7:0] last_good = 8'h00;
    int         n_compared = 0;
    int         n_mismatched = 0;

    // Monitor: records every output pulse together with the held data.
    always @(negedge clk) begin
        if (rx_valid || frame_err || parity_err) begin
            obs_q.push_back('{{parity_err, frame_err, rx_valid}, rx_data, led});
        end
        if (busy) begin
            busy_cycles <= busy_cycles + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Frame-level reference: a low stop bit is a framing error, a wrong
    // parity bit (with a good stop bit) is a parity error, otherwise the
    // byte is delivered. Errors leave the previously delivered byte in place.
    function automatic void modelFrame(input logic [7:0] data, input logic stop_bit,
                                       input logic par_flip);
        frame_evt_t e;
        if (!stop_bit) begin
            e = '{3'b010, last_good, last_good};
        end else if (PARITY_ON && par_flip) begin
            e = '{3'b100, last_good, last_good};
        end else begin
            e = '{3'b001, data, data};
            last_good = data;
        end
        exp_q.push_back(e);
    endfunction

    task automatic holdLine(input logic level, input int clks);
        rx = level;
        repeat (clks) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input logic par_flip);
        modelFrame(data, stop_bit, par_flip);
        holdLine(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            holdLine(data[i], BIT_CLKS);
        end
        if (PARITY_ON) begin
            holdLine((^data) ^ par_flip, BIT_CLKS);
        end
        holdLine(stop_bit, BIT_CLKS);
    endtask

    task automatic checkEvents(input string tag);
        int n_obs = obs_q.size() - obs_rd;
        int n_exp = exp_q.size() - exp_rd;
        checkOutput({tag, " count"}, n_obs, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (obs_rd < obs_q.size()) begin
                checkOutput({tag, " pulses"}, obs_q[obs_rd].pulses, exp_q[exp_rd].pulses);
                checkOutput({tag, " rx_data"}, obs_q[obs_rd].data, exp_q[exp_rd].data);
                checkOutput({tag, " led"}, obs_q[obs_rd].led, exp_q[exp_rd].led);
                obs_rd++;
            end
            exp_rd++;
        end
        obs_rd = obs_q.size();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " rx_data"}, rx_data, 8'h00);
        checkOutput({tag, " rx_valid"}, rx_valid, 1'b0);
        checkOutput({tag, " frame_err"}, frame_err, 1'b0);
        checkOutput({tag, " parity_err"}, parity_err, 1'b0);
        checkOutput({tag, " busy"}, busy, 1'b0);
        checkOutput({tag, " led"}, led, 8'h00);
    endtask

    initial begin
        int         b0;
        logic [7:0] d;
        int         gap;
        logic       flip;

        // Reset with the line held low; it must not start a frame.
        rst = 1'b1;
        rx  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("reset");
        b0 = busy_cycles;
        holdLine(1'b0, 300);
        checkOutput("low after reset busy", busy_cycles - b0, 0);
        checkEvents("low after reset");
        holdLine(1'b1, 2 * BIT_CLKS);

        $display("[TB] single byte 0x5A");
        applyStimulus(8'h5A, 1'b1, 1'b0);
        holdLine(1'b1, BIT_CLKS);
        checkEvents("byte 5A");
        checkOutput("byte 5A idle", busy, 1'b0);

        $display("[TB] back-to-back 0x00, 0xFF");
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        holdLine(1'b1, BIT_CLKS);
        checkEvents("b2b");

        $display("[TB] 40 clk glitch");
        b0 = busy_cycles;
        holdLine(1'b0, 40);
        holdLine(1'b1, 80);
        checkOutput("glitch busy cleared", busy, 1'b0);
        checkOutput("glitch busy seen", (busy_cycles > b0) ? 1 : 0, 1);
        holdLine(1'b1, 2 * BIT_CLKS);
        checkEvents("glitch");

        $display("[TB] framing error on 0xA5 then line held low");
        applyStimulus(8'hA5, 1'b0, 1'b0);
        holdLine(1'b0, 500);
        checkOutput("break busy", busy, 1'b1);
        holdLine(1'b1, 2 * BIT_CLKS);
        checkEvents("frame err");
        checkOutput("frame err held data", rx_data, last_good);
        checkOutput("frame err idle", busy, 1'b0);

        $display("[TB] reset mid bit 4 of 0x3C, then 0xC3");
        d = 8'h3C;
        holdLine(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            holdLine(d[i], BIT_CLKS);
        end
        holdLine(d[4], BIT_CLKS / 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        checkResetOutputs("mid reset");
        holdLine(1'b1, 2 * BIT_CLKS);
        applyStimulus(8'hC3, 1'b1, 1'b0);
        holdLine(1'b1, BIT_CLKS);
        checkEvents("after reset");

        $display("[TB] random frames");
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom_range(0, 255));
            gap  = $urandom_range(0, 2) * (BIT_CLKS / 2);
            flip = PARITY_ON ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus(d, 1'b1, flip);
            if (gap > 0) begin
                holdLine(1'b1, gap);
            end
        end
        holdLine(1'b1, BIT_CLKS);
        checkEvents("random");
        checkOutput("random idle", busy, 1'b0);

        if (PARITY_ON) begin
            $display("[TB] parity good / bad on 0x5A");
            applyStimulus(8'h5A, 1'b1, 1'b0);
            applyStimulus(8'h5A, 1'b1, 1'b1);
            holdLine(1'b1, BIT_CLKS);
            checkEvents("parity");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
